// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU operation codes and the multiplier sequencer state type.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b1001;
    localparam logic [3:0] ALU_LT  = 4'b1010;
    localparam logic [3:0] ALU_GE  = 4'b1011;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SLT = 4'b1110;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Iterative shift-and-add multiplier that borrows the shared
//            datapath ALU while busy. Produces the low DATA_WIDTH bits of
//            op_a*op_b (RV32M MUL, valid for signed and unsigned operands).
// Config   : ALU_MUL_EARLY_TERM_EN - finish as soon as no multiplier bits
//            remain instead of always running DATA_WIDTH iterations.
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int              C_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DATA_WIDTH - 1);

    mul_state_e              r_state;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [C_CNT_W-1:0]      r_cnt;

    logic                    w_accept;
    logic                    w_last;

    // A request is taken in IDLE, and also on the edge leaving DONE so that a
    // held start costs only the single DONE cycle between back-to-back runs.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

`ifdef ALU_MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == C_LAST) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_cnt == C_LAST);
`endif

    // ALU request decode: accumulate in ADD, double the multiplicand in SHIFT.
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = OPCODE_LENGTH'(ALU_ADD);
        case (r_state)
            ADD: begin
                alu_srca = r_acc;
                alu_srcb = r_mcand;
                alu_op   = OPCODE_LENGTH'(ALU_ADD);
            end
            SHIFT: begin
                alu_srca = r_mcand;
                alu_srcb = DATA_WIDTH'(1);
                alu_op   = OPCODE_LENGTH'(ALU_SLL);
            end
            default: ;
        endcase
    end

    // Sequencer FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_result;
                    end
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_mcand  <= alu_result;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        result  <= r_acc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= ADD;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Operand capture overrides the per-state next state above.
            if (w_accept) begin
                r_mcand  <= op_a;
                r_mplier <= op_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= ADD;
            end
        end
    end

endmodule : alu_mul_seq
`default_nettype wire
